twos_serial_negate: RTL and testbench

- Parametrised, bit-serial two's-complement unit for the arithmetic datapath.
- Accepts a WIDTH-bit operand and a mode on a valid/ready handshake.
- Computes pass, negate or absolute value one bit per clock, using invert-plus-carry from the LSB upward, with a single stateful carry.
- Presents the result on a valid/ready output together with overflow and zero flags.

---
 rtl/twos_serial_negate.sv | 92 +++++++++
 tb/tb_twos_serial_negate.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/twos_serial_negate.sv
// Bit-serial two's-complement pass / negate / absolute value, one bit per clock from the LSB up.
// Latency: result valid WIDTH+1 cycles after accept; backpressure: holds DONE until out_ready, in_ready low while busy.
// Backpressure: in_ready is low for the whole RUN/DONE span, and the result is held for as long as out_ready stays low.
module twos_serial_negate #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             invert, carry, ovf_pend;

    logic             in_invert, t, rbit, last;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        in_invert = (in_mode == 2'b01) | ((in_mode == 2'b10) & in_data[WIDTH-1]);
        t         = sr[0] ^ invert;
        rbit      = t ^ carry;
        // operand bits shift out at the bottom while result bits enter at the top
        res_nxt   = {rbit, sr[WIDTH-1:1]};
        last      = (cnt == CW'(WIDTH - 1));
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            invert   <= 1'b0;
            carry    <= 1'b0;
            ovf_pend <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= in_data;
                        invert   <= in_invert;
                        carry    <= in_invert;
                        cnt      <= '0;
                        ovf_pend <= in_invert & in_data[WIDTH-1] & ~|in_data[WIDTH-2:0];
                    end
                end
                RUN: begin
                    sr    <= res_nxt;
                    carry <= t & carry;
                    cnt   <= cnt + CW'(1);
                    // final carry-out is dropped: arithmetic is modulo 2^WIDTH
                    if (last) begin
                        out_data <= res_nxt;
                        out_zero <= ~|res_nxt;
                        out_ovf  <= ovf_pend;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_twos_serial_negate.sv
// Scoreboarded bench for twos_serial_negate at WIDTH 4, 8 and 16 running side by side.
module tb_twos_serial_negate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gw
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 16;

        logic         reset_n, in_valid, in_ready, out_valid, out_ready;
        logic         out_ovf, out_zero, busy;
        logic [W-1:0] in_data, out_data;
        logic [1:0]   in_mode;
        logic [W+1:0] expq[$];
        bit           done = 1'b0;

        twos_serial_negate #(.WIDTH(W)) dut (
            .clk(clk), .reset_n(reset_n),
            .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
            .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
            .out_ovf(out_ovf), .out_zero(out_zero), .busy(busy)
        );

        // Reference: signed arithmetic modulo 2^W, packed as {result, ovf, zero}
        function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [1:0] m);
            longint       v, r, modv, mn;
            bit           neg;
            logic [W-1:0] rr;
            modv = longint'(1) << W;
            mn   = longint'(1) << (W - 1);
            v    = longint'(a);
            neg  = (m == 2'd1) || (m == 2'd2 && v >= mn);
            r    = neg ? (modv - v) % modv : v;
            rr   = W'(r);
            return {rr, neg && (v == mn), r == 0};
        endfunction

        task automatic drive_junk(input bit j);
            in_valid = j ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = W'($urandom);
            in_mode  = 2'($urandom);
        endtask

        task automatic op(input logic [W-1:0] a, input logic [1:0] m, input bit junk, input int hold);
            int n, lat;
            logic [W+1:0] e;
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk); #1; n++;
            end
            check($sformatf("w%0d_in_ready", W), in_ready, 1);
            e = model(a, m);
            in_valid = 1'b1; in_data = a; in_mode = m; out_ready = (hold == 0);
            expq.push_back(e);
            @(posedge clk); #1;
            drive_junk(junk);
            lat = 0;
            forever begin
                @(negedge clk); lat++;
                if (out_valid || lat > 4 * W) break;
                @(posedge clk); #1; drive_junk(junk);
            end
            check($sformatf("w%0d_latency", W), lat, W + 1);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1; drive_junk(junk);
                @(negedge clk);
                check($sformatf("w%0d_hold_vld", W), out_valid, 1);
                check($sformatf("w%0d_hold_dat", W), {out_data, out_ovf, out_zero}, e);
                check($sformatf("w%0d_hold_rdy", W), in_ready, 0);
            end
            if (hold > 0) begin
                @(posedge clk); #1; out_ready = 1'b1; in_valid = 1'b0;
            end
            @(posedge clk); #1; in_valid = 1'b0;
            check($sformatf("w%0d_post_vld", W), out_valid, 0);
        endtask

        always @(negedge clk) begin
            if (reset_n && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check($sformatf("w%0d_unexpected_out", W), 1, 0);
                end else begin
                    check($sformatf("w%0d_result", W), {out_data, out_ovf, out_zero}, expq.pop_front());
                end
            end
        end

        initial begin
            logic [W-1:0] mn;
            bit seen;
            mn = W'(1) << (W - 1);
            reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1;
            @(posedge clk); #1;
            check($sformatf("w%0d_rst_state", W),
                  {out_valid, busy, in_ready, out_ovf, out_zero, out_data}, {3'b001, 2'b00, W'(0)});
            @(posedge clk); #1; reset_n = 1'b1;

            op(W'(5), 2'd1, 0, 0);
            op(W'(32'h9C), 2'd2, 0, 0);
            op(W'(32'h64), 2'd2, 0, 0);
            op(mn, 2'd2, 0, 0);
            op(mn, 2'd1, 0, 0);
            op(W'(0), 2'd1, 0, 0);
            op(W'(32'hA5A5), 2'd3, 0, 0);
            op(W'(1), 2'd1, 0, 0);
            op(W'(32'h3C3C), 2'd1, 1, 5);

            // reset while RUN is processing bit 3
            in_valid = 1'b1; in_data = W'(32'h5555); in_mode = 2'd1;
            @(posedge clk); #1; in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1; reset_n = 1'b0;
            @(posedge clk); #1; reset_n = 1'b1;
            check($sformatf("w%0d_abort_state", W),
                  {out_valid, busy, in_ready, out_ovf, out_zero, out_data}, {3'b001, 2'b00, W'(0)});
            seen = 1'b0;
            repeat (W + 3) begin
                @(negedge clk); seen |= out_valid;
            end
            check($sformatf("w%0d_abort_no_vld", W), seen, 0);
            @(posedge clk); #1;
            op(mn - W'(1), 2'd1, 0, 0);

            for (int i = 0; i < 30; i++)
                op(W'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 2));

            repeat (3) @(posedge clk);
            check($sformatf("w%0d_queue_empty", W), expq.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(gw[0].done && gw[1].done && gw[2].done) && t < 50000) begin
            @(posedge clk); t++;
        end
        check("timeout", t < 50000, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
